vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA output path: samples HS/VS/1-bit RGB at the pixel clock and recovers pixel coordinates, data-enable and colour.
- Checks line and frame timing against 640x480@60 parameters and runs a lock state machine.
- Provides a single-pixel probe capture for self-test and board bring-up loopback.
- Sits in the same pixel-clock domain as the VGA controller; no clock crossing.

---
 rtl/vga_sync_decoder.sv | 166 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, DE and colour from a sampled VGA stream
// and tracks timing lock against the configured video mode.
module vga_sync_decoder #(
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   H_ACT       = 640,
    parameter int   H_FRONT     = 16,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   V_ACT       = 480,
    parameter int   V_FRONT     = 10,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        iCLK,
    input  logic        reset,
    input  logic        iVGA_HS,
    input  logic        iVGA_VS,
    input  logic        iVGA_R,
    input  logic        iVGA_G,
    input  logic        iVGA_B,
    input  logic [9:0]  iProbe_X,
    input  logic [9:0]  iProbe_Y,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oDE,
    output logic        oR,
    output logic        oG,
    output logic        oB,
    output logic        oLocked,
    output logic        oFrame_Start,
    output logic        oH_Err,
    output logic        oV_Err,
    output logic        oProbe_Valid,
    output logic [2:0]  oProbe_RGB,
    output logic [15:0] oFrame_Cnt
);
    localparam logic [9:0] H_TOTAL = 10'(H_SYNC + H_BACK + H_ACT + H_FRONT);
    localparam logic [9:0] H_LAST  = H_TOTAL - 10'd1;
    localparam logic [9:0] H_SM1   = 10'(H_SYNC - 1);
    localparam logic [9:0] H_A0    = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_A1    = 10'(H_SYNC + H_BACK + H_ACT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BACK + V_ACT + V_FRONT - 1);
    localparam logic [9:0] V_SM1   = 10'(V_SYNC - 1);
    localparam logic [9:0] V_A0    = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_A1    = 10'(V_SYNC + V_BACK + V_ACT - 1);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

    state_t     state;
    logic       s_hs, s_vs, s_r, s_g, s_b;
    logic       hs_act_d, vs_prev, err_seen;
    logic [9:0] h_cnt, v_cnt;
    logic [7:0] good_cnt;

    logic       hs_act, vs_act, hs_rise, hs_fall, vs_start, vs_end;
    logic       h_err, v_err, err, active, de;
    logic [9:0] h_inc, v_inc, h_nxt, v_nxt;

    // h_nxt/v_nxt are the coordinates of the pixel currently held in s_*,
    // so colour and position leave the output stage aligned.
    always_comb begin
        hs_act   = s_hs == HS_POL;
        vs_act   = s_vs == VS_POL;
        hs_rise  = hs_act & ~hs_act_d;
        hs_fall  = ~hs_act & hs_act_d;
        vs_start = hs_rise & vs_act & ~vs_prev;
        vs_end   = hs_rise & ~vs_act & vs_prev;
        h_inc    = &h_cnt ? h_cnt : h_cnt + 10'd1;
        v_inc    = &v_cnt ? v_cnt : v_cnt + 10'd1;
        h_nxt    = hs_rise ? 10'd0 : h_inc;
        v_nxt    = vs_start ? 10'd0 : hs_rise ? v_inc : v_cnt;
        h_err    = state != HUNT && ((hs_rise && h_cnt != H_LAST) ||
                   (hs_fall && h_cnt != H_SM1) || (!hs_rise && h_cnt == H_TOTAL));
        v_err    = state != HUNT && ((vs_start && v_cnt != V_LAST) ||
                   (vs_end && v_cnt != V_SM1));
        err      = h_err | v_err;
        active   = h_nxt >= H_A0 && h_nxt <= H_A1 && v_nxt >= V_A0 && v_nxt <= V_A1;
        de       = active && state == LOCKED && !err;
    end

    assign oProbe_Valid = oDE && oX == iProbe_X && oY == iProbe_Y;

    always_ff @(posedge iCLK) begin
        if (reset) begin
            s_hs         <= ~HS_POL;
            s_vs         <= ~VS_POL;
            s_r          <= 1'b0;
            s_g          <= 1'b0;
            s_b          <= 1'b0;
            hs_act_d     <= 1'b0;
            vs_prev      <= 1'b0;
            err_seen     <= 1'b0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            good_cnt     <= '0;
            state        <= HUNT;
            oX           <= '0;
            oY           <= '0;
            oDE          <= 1'b0;
            oR           <= 1'b0;
            oG           <= 1'b0;
            oB           <= 1'b0;
            oLocked      <= 1'b0;
            oFrame_Start <= 1'b0;
            oH_Err       <= 1'b0;
            oV_Err       <= 1'b0;
            oProbe_RGB   <= '0;
            oFrame_Cnt   <= '0;
        end else begin
            s_hs         <= iVGA_HS;
            s_vs         <= iVGA_VS;
            s_r          <= iVGA_R;
            s_g          <= iVGA_G;
            s_b          <= iVGA_B;
            hs_act_d     <= hs_act;
            vs_prev      <= hs_rise ? vs_act : vs_prev;
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            oH_Err       <= h_err;
            oV_Err       <= v_err;
            oDE          <= de;
            oX           <= de ? h_nxt - H_A0 : '0;
            oY           <= de ? v_nxt - V_A0 : '0;
            oR           <= de & s_r;
            oG           <= de & s_g;
            oB           <= de & s_b;
            oFrame_Start <= 1'b0;
            if (oProbe_Valid)
                oProbe_RGB <= {oR, oG, oB};
            case (state)
                HUNT: if (vs_start) begin
                    state    <= ACQUIRE;
                    good_cnt <= '0;
                    err_seen <= 1'b0;
                end
                ACQUIRE: if (vs_start) begin
                    err_seen <= 1'b0;
                    if (err || err_seen)
                        good_cnt <= '0;
                    else if (good_cnt + 8'd1 == LOCK_N) begin
                        state        <= LOCKED;
                        good_cnt     <= '0;
                        oLocked      <= 1'b1;
                        oFrame_Start <= 1'b1;
                        oFrame_Cnt   <= oFrame_Cnt + 16'd1;
                    end else
                        good_cnt <= good_cnt + 8'd1;
                end else if (err) begin
                    err_seen <= 1'b1;
                    good_cnt <= '0;
                end
                LOCKED: if (err) begin
                    state   <= HUNT;
                    oLocked <= 1'b0;
                end else if (vs_start) begin
                    oFrame_Start <= 1'b1;
                    oFrame_Cnt   <= oFrame_Cnt + 16'd1;
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a reduced-size VGA mode and scores recovered pixels,
// lock behaviour, error pulses and the probe capture.
module tb_vga_sync_decoder;
    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int RP = 11;

    logic        clk = 0, reset = 1, hs = 1, vs = 1, r = 0, g = 0, b = 0;
    logic [9:0]  px_probe = 10'd8, py_probe = 10'd0;
    logic [9:0]  oX, oY;
    logic        oDE, oR, oG, oB, oLocked, oFrame_Start, oH_Err, oV_Err, oProbe_Valid;
    logic [2:0]  oProbe_RGB;
    logic [15:0] oFrame_Cnt;

    typedef struct {int x; int y; logic [2:0] rgb; int cyc;} exp_t;
    exp_t q[$];

    int   cyc = 0, checks = 0, passed = 0;
    int   h_errs = 0, v_errs = 0, fs_cnt = 0, pv_cnt = 0;
    int   lock_rise = 0, rst_chk = -1, frame_cyc = 0;
    logic locked_d = 0;

    vga_sync_decoder #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .iCLK(clk), .reset(reset), .iVGA_HS(hs), .iVGA_VS(vs),
        .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
        .iProbe_X(px_probe), .iProbe_Y(py_probe),
        .oX(oX), .oY(oY), .oDE(oDE), .oR(oR), .oG(oG), .oB(oB),
        .oLocked(oLocked), .oFrame_Start(oFrame_Start),
        .oH_Err(oH_Err), .oV_Err(oV_Err),
        .oProbe_Valid(oProbe_Valid), .oProbe_RGB(oProbe_RGB), .oFrame_Cnt(oFrame_Cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (oDE) begin
            if (q.size() == 0) check("de_extra", oDE, 0);
            else begin
                e = q.pop_front();
                check("x", oX, e.x);
                check("y", oY, e.y);
                check("rgb", {oR, oG, oB}, e.rgb);
                check("latency", cyc - e.cyc, 2);
            end
        end else
            check("blank", {oR, oG, oB, oX, oY}, 0);
        if (oH_Err) h_errs++;
        if (oV_Err) v_errs++;
        if (oH_Err | oV_Err) check("err_lock", oLocked, 0);
        if (oFrame_Start) fs_cnt++;
        if (oProbe_Valid) begin
            pv_cnt++;
            check("probe_xy", {oX, oY}, {px_probe, py_probe});
        end
        if (oLocked & ~locked_d) lock_rise = cyc;
        locked_d = oLocked;
        if (cyc == rst_chk)
            check("rst_mid", {oX, oY, oDE, oR, oG, oB, oLocked, oFrame_Start, oH_Err,
                              oV_Err, oProbe_Valid, oProbe_RGB, oFrame_Cnt}, 0);
    end

    // One frame; lk = number of leading lines whose active pixels are expected on oDE.
    task automatic send_frame(input int lk, input int vsl, input int short_l,
                              input int stall_l, input int rst_l, input bit probe);
        logic [2:0] c;
        bit act;
        for (int ln = 0; ln < VT; ln++) begin
            for (int p = 0; p < ((ln == short_l) ? HT - 1 : HT); p++) begin
                @(negedge clk);
                act = p >= HS + HB && p < HS + HB + HA && ln >= VS + VB && ln < VS + VB + VA;
                c = probe ? ((act && p == HS + HB + HA - 1 && ln == VS + VB + VA - 1) ? 3'b100 : 3'b000)
                          : 3'($urandom);
                hs = (p < HS) ? 1'b0 : 1'b1;
                vs = (ln < vsl) ? 1'b0 : 1'b1;
                {r, g, b} = c;
                reset = (ln == rst_l && p == RP);
                if (reset) rst_chk = cyc + 1;
                if (ln == 0 && p == 0) frame_cyc = cyc;
                if (act && ln < lk && !(ln == rst_l && p > RP - 2))
                    q.push_back('{p - (HS + HB), ln - (VS + VB), c, cyc});
            end
            if (ln == stall_l) repeat (2000) @(negedge clk);
        end
        check("de_count", q.size(), 0);
    endtask

    task automatic relock();
        send_frame(0, VS, -1, -1, -1, 0);
        send_frame(0, VS, -1, -1, -1, 0);
        send_frame(VT, VS, -1, -1, -1, 0);
        check("lock_rise", lock_rise - frame_cyc, 2);
        check("locked", oLocked, 1);
    endtask

    initial begin
        int he, ve;
        repeat (3) @(negedge clk);
        check("rst_out", {oX, oY, oDE, oR, oG, oB, oLocked, oFrame_Start, oH_Err,
                          oV_Err, oProbe_Valid, oProbe_RGB, oFrame_Cnt}, 0);
        relock();
        send_frame(VT, VS, -1, -1, -1, 0);
        check("fcnt_nom", oFrame_Cnt, 2);
        check("fs_nom", fs_cnt, 2);
        check("herr_nom", h_errs, 0);
        check("verr_nom", v_errs, 0);
        check("probe_oob", pv_cnt, 0);
        check("probe_rgb0", oProbe_RGB, 0);

        px_probe = 10'(HA - 1);
        py_probe = 10'(VA - 1);
        send_frame(VT, VS, -1, -1, -1, 1);
        send_frame(VT, VS, -1, -1, -1, 1);
        check("probe_cnt", pv_cnt, 2);
        check("probe_rgb", oProbe_RGB, 3'b100);
        check("fcnt_probe", oFrame_Cnt, 4);

        he = h_errs; ve = v_errs;
        send_frame(6, VS, 5, -1, -1, 0);
        check("short_herr", h_errs - he, 1);
        check("short_verr", v_errs - ve, 0);
        check("short_unlock", oLocked, 0);
        relock();

        he = h_errs; ve = v_errs;
        send_frame(0, 3, -1, -1, -1, 0);
        check("vs3_verr", v_errs - ve, 1);
        check("vs3_herr", h_errs - he, 0);
        check("vs3_unlock", oLocked, 0);
        relock();

        he = h_errs; ve = v_errs;
        send_frame(6, VS, -1, 5, -1, 0);
        check("stall_herr", h_errs - he, 1);
        check("stall_verr", v_errs - ve, 0);
        relock();

        send_frame(6, VS, -1, -1, 5, 0);
        check("rst_fcnt", oFrame_Cnt, 0);
        check("rst_unlock", oLocked, 0);
        relock();
        check("relock_fcnt", oFrame_Cnt, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
